sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-master arbiter sharing one SRAM-like memory port between the instruction-fetch requester and the MEM-stage data requester. Sits between the pipeline front end / MEM stage and the single external SRAM-like port, replacing separate inst/data SRAMs. It holds a granted request stable until the address handshake completes and tracks in-order outstanding transactions so that each `data_ok` returns to its issuer.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unreturned transactions, at least 1.
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req`, `inst_wr`  in  1 each  fetch request; write flag.
- `inst_size`  in  2  access size; 0 = byte, 1 = half, 2 = word.
- `inst_addr`, `inst_wdata`  in  32 each  address; write data.
- `inst_wstrb`  in  4  byte write strobes.
- `inst_addr_ok`, `inst_data_ok`  out  1 each  address accepted; response valid.
- `inst_rdata`  out  32  read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same signals for the MEM-stage requester.
- `req`, `wr`  out  1 each  shared-port request; write flag.
- `size`  out  2  shared-port access size.
- `addr`, `wdata`  out  32 each  shared-port address; write data.
- `wstrb`  out  4  shared-port byte strobes.
- `addr_ok`, `data_ok`  in  1 each  slave address accept; slave response.
- `rdata`  in  32  slave read data.
- `err_orphan`  out  1  sticky flag: `data_ok` arrived with nothing outstanding.

## Operation
- An address handshake completes on `req & addr_ok` at a rising edge.
- Each requester holds its request and payload stable until its own `*_addr_ok`.
- Grant:
  - If `lock_vld`, the grant is `lock_id`.
  - Otherwise data wins over inst when both request. Fixed priority; data starvation of inst is accepted.
- Lock register:
  - Set to the granted id when `req & ~addr_ok & ~full`.
  - Cleared on `req & addr_ok`.
  - A higher-priority request never preempts a locked grant.
- `full = (count == OUTSTANDING)`. When full:
  - `req = 0` and both `*_addr_ok = 0`.
  - The lock is retained.
- Shared-port mux:
  - `req = granted_req & ~full`.
  - `wr/size/addr/wstrb/wdata` come from the granted requester.
  - With no request, the payload outputs are 0.
- Address acknowledge: `<grant>_addr_ok = addr_ok & req` for the granted requester; 0 for the other.
- ID FIFO:
  - Push the granted id on each completed address handshake.
  - Pop on `data_ok` when `count != 0`.
- Response routing:
  - `data_ok` is steered to `inst_data_ok` or `data_data_ok` by the FIFO head.
  - `rdata` is broadcast to both `*_rdata`.
  - Write responses also pop the FIFO.
- Simultaneous push and pop:
  - Allowed when `count < OUTSTANDING`; `count` is unchanged.
  - A push is never taken when full, even if a pop happens in the same cycle. This is conservative and removes the combinational path from `data_ok` to `addr_ok`.
- Orphan response: `data_ok` with `count == 0` is dropped (no `*_data_ok` asserted) and sets `err_orphan`, which stays set until reset.
- Ordering: the slave returns responses in acceptance order. The arbiter does no hazard checking.

## Timing
- Reset values:
  - `count=0`, `lock_vld=0`, FIFO pointers 0, `err_orphan=0`.
  - All outputs 0 (`req`, `*_addr_ok`, `*_data_ok`, payload, `*_rdata` except the `rdata` passthrough).
- Zero-cycle request path: `*_req` to `req` and `addr_ok` to `*_addr_ok` are combinational in the same cycle.
- Zero-cycle response path: `data_ok` to `*_data_ok` is combinational through the registered FIFO head.
- Count, lock, FIFO and `err_orphan` update on the rising edge after the event.
- A transaction accepted in cycle N may return earliest at N+1; with the fastest slave, `data_ok` in cycle N+1 pops the id pushed at N.
- Reset mid-operation:
  - Clears all outstanding state immediately, asynchronously.
  - The slave shares `resetn`, so no stale responses follow.

## Structure
- Shared package `mem_bus_pkg`:
  - `ID_INST=1'b0`, `ID_DATA=1'b1`.
  - `SIZE_B/H/W` encodings.
  - Default `OUTSTANDING`.
- Sub-module `id_fifo`:
  - Synchronous FIFO, width 1, depth `OUTSTANDING`, async active-low reset.
  - Ports: push, pop, head, count, full, empty.
- Top level holds the grant logic, lock register, payload mux and response steering.

## Test plan
- Single inst read, addr 0x1C000000, `addr_ok` same cycle, `data_ok` + `rdata`=0x02A00000 one cycle later -> `inst_addr_ok` pulse, `inst_data_ok` with 0x02A00000, `data_data_ok` stays 0.
- Inst and data request in the same cycle, both `addr_ok` immediately -> data granted first (`addr`=data address), inst next cycle; responses return in order data then inst.
- Inst request, `addr_ok` held low 3 cycles, data request arrives in cycle 1 -> `addr` stays on inst through the handshake; data granted in the following cycle.
- `OUTSTANDING`=2, two reads accepted, no `data_ok` -> third request sees `req=0` and `*_addr_ok=0`; after one `data_ok` it is accepted next cycle.
- `count`=1, `data_ok` and a new handshake in the same cycle -> `count` stays 1 and the FIFO head becomes the new id.
- `data_ok` with nothing outstanding -> no `*_data_ok`, `err_orphan`=1 and held. Assert `resetn`=0 mid-cycle -> `err_orphan`, `count` and `req` all 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared ids, access-size encodings and the request payload bundle for the SRAM-like bus.
package mem_bus_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int OUTSTANDING_DEF = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/id_fifo.sv
// In-order record of which requester owns each outstanding transaction.
// Latency: head valid the cycle after push; push ignored when full, pop ignored when empty.
module id_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       push_dat_i,
  input  logic                       pop_i,
  output logic                       head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch and MEM requesters; data has fixed priority.
// Latency: zero-cycle request and response paths; when OUTSTANDING responses are owed, req is held low.
module sram_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        err_orphan
);

  localparam int CW = $clog2(OUTSTANDING + 1);

  bus_req_t      inst_p, data_p, gnt_p;
  logic          grant_id, granted_req, handshake;
  logic          lock_vld_q, lock_vld_d, lock_id_q, lock_id_d;
  logic          err_q, err_d;
  logic          fifo_head, fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;

  assign inst_p = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
  assign data_p = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

  // A stalled grant stays with its owner even if data shows up meanwhile.
  assign grant_id    = lock_vld_q ? lock_id_q : (data_req ? ID_DATA : ID_INST);
  assign granted_req = (grant_id == ID_DATA) ? data_req : inst_req;
  assign req         = granted_req & ~fifo_full & resetn;
  assign gnt_p       = !req ? '0 : ((grant_id == ID_DATA) ? data_p : inst_p);
  assign {wr, size, addr, wstrb, wdata} = gnt_p;

  assign handshake    = req & addr_ok;
  assign inst_addr_ok = handshake & (grant_id == ID_INST);
  assign data_addr_ok = handshake & (grant_id == ID_DATA);

  assign pop          = data_ok & ~fifo_empty;
  assign inst_data_ok = pop & (fifo_head == ID_INST);
  assign data_data_ok = pop & (fifo_head == ID_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign err_orphan   = err_q;

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (handshake) begin
      lock_vld_d = 1'b0;
    end else if (req) begin
      lock_vld_d = 1'b1;
      lock_id_d  = grant_id;
    end
  end

  assign err_d = err_q | (data_ok & (fifo_count == '0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= ID_INST;
      err_q      <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      err_q      <= err_d;
    end
  end

  id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
    .clk        (clk),
    .rst_n      (resetn),
    .push_i     (handshake),
    .push_dat_i (grant_id),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model of the arbiter.
module tb_sram_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int OUT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        err_orphan;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err_orphan(err_orphan)
  );

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = SIZE_W; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    addr_ok = 0; data_ok = 0; rdata = 0;
  endtask

  task automatic test_reset();
    resetn = 0; idle();
    @(negedge clk); #1;
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b exp 0", req); end
    n_tests++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", addr); end
    n_tests++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      n_fail++; $display("FAIL reset_acks got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err_orphan); end
    @(negedge clk); resetn = 1;
  endtask

  task automatic test_single_inst();
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = SIZE_W; addr_ok = 1; #1;
    n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL single_req got %0b exp 1", req); end
    n_tests++; if (addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL single_addr got %h exp 1c000000", addr); end
    n_tests++; if (size !== SIZE_W) begin n_fail++; $display("FAIL single_size got %0d exp 2", size); end
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL single_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk); inst_req = 0; inst_addr = 0; addr_ok = 0; data_ok = 1; rdata = 32'h02A0_0000; #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      n_fail++; $display("FAIL single_data_ok got %b exp 10", {inst_data_ok, data_data_ok}); end
    n_tests++; if (inst_rdata !== 32'h02A0_0000) begin n_fail++; $display("FAIL single_rdata got %h exp 02a00000", inst_rdata); end
    @(negedge clk); idle();
  endtask

  task automatic test_both_same_cycle();
    inst_req = 1; inst_addr = 32'h1C00_0004; data_req = 1; data_addr = 32'h8000_1000; addr_ok = 1; #1;
    n_tests++; if (addr !== 32'h8000_1000) begin n_fail++; $display("FAIL both_first_addr got %h exp 80001000", addr); end
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      n_fail++; $display("FAIL both_first_ack got %b exp 01", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk); data_req = 0; #1;
    n_tests++; if (addr !== 32'h1C00_0004) begin n_fail++; $display("FAIL both_second_addr got %h exp 1c000004", addr); end
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL both_second_ack got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk); inst_req = 0; addr_ok = 0; data_ok = 1; #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      n_fail++; $display("FAIL both_resp1 got %b exp 01", {inst_data_ok, data_data_ok}); end
    @(negedge clk); #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      n_fail++; $display("FAIL both_resp2 got %b exp 10", {inst_data_ok, data_data_ok}); end
    @(negedge clk); idle();
  endtask

  task automatic test_lock();
    inst_req = 1; inst_addr = 32'h1C00_0008; addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_req = 1; data_addr = 32'h8000_2000; end
      #1;
      n_tests++; if (addr !== 32'h1C00_0008) begin n_fail++; $display("FAIL lock_hold_c%0d got %h exp 1c000008", c, addr); end
      @(negedge clk);
    end
    addr_ok = 1; #1;
    n_tests++; if (addr !== 32'h1C00_0008) begin n_fail++; $display("FAIL lock_hs_addr got %h exp 1c000008", addr); end
    n_tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL lock_hs_ack got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk); inst_req = 0; #1;
    n_tests++; if (addr !== 32'h8000_2000 || data_addr_ok !== 1'b1) begin
      n_fail++; $display("FAIL lock_next got addr %h ack %0b exp 80002000 1", addr, data_addr_ok); end
    @(negedge clk); data_req = 0; addr_ok = 0; data_ok = 1; #1;
    n_tests++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL lock_resp1 got %0b exp 1", inst_data_ok); end
    @(negedge clk); #1;
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL lock_resp2 got %0b exp 1", data_data_ok); end
    @(negedge clk); idle();
  endtask

  task automatic test_full();
    data_req = 1; data_addr = 32'h8000_3000; addr_ok = 1;
    @(negedge clk); data_addr = 32'h8000_3004;
    @(negedge clk); data_addr = 32'h8000_3008; #1;
    n_tests++; if ({req, data_addr_ok} !== 2'b00) begin
      n_fail++; $display("FAIL full_block got req,ack %b exp 00", {req, data_addr_ok}); end
    @(negedge clk); data_ok = 1; #1;
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_pop got req %0b exp 0", req); end
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_pop_resp got %0b exp 1", data_data_ok); end
    @(negedge clk); data_ok = 0; #1;
    n_tests++; if (req !== 1'b1 || data_addr_ok !== 1'b1 || addr !== 32'h8000_3008) begin
      n_fail++; $display("FAIL full_resume got req %0b ack %0b addr %h exp 1 1 80003008", req, data_addr_ok, addr); end
    @(negedge clk); data_req = 0; addr_ok = 0; data_ok = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_drain%0d got %0b exp 1", k, data_data_ok); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_push_pop();
    inst_req = 1; inst_addr = 32'h1C00_0010; addr_ok = 1;
    @(negedge clk); inst_req = 0; data_req = 1; data_addr = 32'h8000_4000; data_ok = 1; #1;
    n_tests++; if ({inst_data_ok, data_addr_ok} !== 2'b11) begin
      n_fail++; $display("FAIL pp_both got data_ok,addr_ok %b exp 11", {inst_data_ok, data_addr_ok}); end
    @(negedge clk); data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0014; #1;
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL pp_head got %0b exp 1", data_data_ok); end
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL pp_count got inst_addr_ok %0b exp 1", inst_addr_ok); end
    @(negedge clk); inst_req = 0; addr_ok = 0; #1;
    n_tests++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL pp_last got %0b exp 1", inst_data_ok); end
    @(negedge clk); idle();
  endtask

  task automatic test_random();
    bit          pi = 0, pd = 0, er, ei, edd;
    logic [31:0] ia = 0, da = 0, dwd = 0, ea;
    int          held = -1, g;
    bit          q[$];
    bit          done = 0;
    for (int c = 0; c < 700; c++) begin
      if (c < 600) begin
        if (!pi && $urandom_range(1, 0) == 1) begin pi = 1; ia = $urandom; end
        if (!pd && $urandom_range(2, 0) == 0) begin pd = 1; da = $urandom; dwd = $urandom; end
        addr_ok = ($urandom_range(3, 0) != 0);
        data_ok = (q.size() > 0) && ($urandom_range(2, 0) != 0);
      end else begin
        if (!pi && !pd && q.size() == 0) begin done = 1; break; end
        addr_ok = 1;
        data_ok = (q.size() > 0);
      end
      inst_req = pi; inst_addr = ia; data_req = pd; data_addr = da; data_wdata = dwd; data_wr = 1;
      rdata = $urandom;
      #1;
      g   = (held >= 0) ? held : (pd ? 1 : 0);
      er  = ((g == 1) ? pd : pi) && (q.size() < OUT);
      ea  = er ? ((g == 1) ? da : ia) : 32'h0;
      ei  = data_ok && q.size() > 0 && q[0] == 1'b0;
      edd = data_ok && q.size() > 0 && q[0] == 1'b1;
      n_tests++; if (req !== er) begin n_fail++; $display("FAIL rnd_req c%0d got %0b exp %0b", c, req, er); end
      n_tests++; if (addr !== ea) begin n_fail++; $display("FAIL rnd_addr c%0d got %h exp %h", c, addr, ea); end
      n_tests++; if ({inst_addr_ok, data_addr_ok} !== {er && addr_ok && g == 0, er && addr_ok && g == 1}) begin
        n_fail++; $display("FAIL rnd_addr_ok c%0d got %b grant %0d", c, {inst_addr_ok, data_addr_ok}, g); end
      n_tests++; if ({inst_data_ok, data_data_ok} !== {ei, edd}) begin
        n_fail++; $display("FAIL rnd_data_ok c%0d got %b exp %b", c, {inst_data_ok, data_data_ok}, {ei, edd}); end
      n_tests++; if (data_rdata !== rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, data_rdata, rdata); end
      if (data_ok && q.size() > 0) void'(q.pop_front());
      if (er && addr_ok) begin
        q.push_back(g == 1);
        held = -1;
        if (g == 1) pd = 0; else pi = 0;
      end else if (er) begin
        held = g;
      end
      @(negedge clk);
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL rnd_drain got outstanding %0d exp 0", q.size()); end
    idle();
  endtask

  task automatic test_orphan_and_reset();
    data_ok = 1; #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_fail++; $display("FAIL orphan_drop got %b exp 00", {inst_data_ok, data_data_ok}); end
    @(negedge clk); data_ok = 0; #1;
    n_tests++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_set got %0b exp 1", err_orphan); end
    @(negedge clk); #1;
    n_tests++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_hold got %0b exp 1", err_orphan); end
    inst_req = 1; inst_addr = 32'h1C00_0020; addr_ok = 1;
    @(negedge clk); addr_ok = 0; #2;
    resetn = 0; #1;
    n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL async_err got %0b exp 0", err_orphan); end
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL async_req got %0b exp 0", req); end
    @(negedge clk); resetn = 1; addr_ok = 1; #1;
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL post_reset_acc1 got %0b exp 1", inst_addr_ok); end
    @(negedge clk); inst_req = 0; data_req = 1; data_addr = 32'h8000_5000; #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL post_reset_acc2 got %0b exp 1", data_addr_ok); end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_both_same_cycle();
    test_lock();
    test_full();
    test_push_pop();
    test_random();
    test_orphan_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
